count_seq_checker: RTL and testbench

Receive-side monitor for the modulo-100 counter stream (0..99, wrapping to 0). Samples a count bus each qualified clock and locks onto the sequence after a run of consecutive correct values. Once locked, it flags any break in the sequence and keeps error and wrap statistics. It sits beside or downstream of counter_100 as a self-checking consumer of its output.

---
 rtl/count_seq_checker_pkg.sv | 26 ++
 rtl/count_seq_checker_if.sv | 33 +++
 rtl/count_seq_checker_sat_counter.sv | 35 +++
 rtl/count_seq_checker.sv | 131 +++++++++++++
 tb/tb_count_seq_checker.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/count_seq_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_checker_pkg
//  Description : Shared types and helpers for the modulo counter stream
//                checker: FSM state encoding, default wrap value and the
//                next-count function.
//  Revision    : 1.0 - initial release
// ============================================================================
package count_seq_checker_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int DEF_CNT_MAX = 99;

   // Successor of x in a counter that wraps from max_val back to zero.
   function automatic int unsigned next_count(input int unsigned x,
                                              input int unsigned max_val);
      return (x == max_val) ? 32'd0 : x + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/count_seq_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_checker_if
//  Description : Sample/statistics bundle between a count stream source and
//                the sequence checker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface count_seq_checker_if #(
   parameter int CNT_W  = 7,
   parameter int ERR_W  = 8,
   parameter int WRAP_W = 16
);
   logic              i_valid;
   logic [CNT_W-1:0]  i_cnt;
   logic              i_clear;
   logic              o_locked;
   logic              o_err_pulse;
   logic [ERR_W-1:0]  o_err_cnt;
   logic [WRAP_W-1:0] o_wrap_cnt;
   logic [1:0]        o_state;
   logic [CNT_W-1:0]  o_expected;

   modport master (
      output i_valid, i_cnt, i_clear,
      input  o_locked, o_err_pulse, o_err_cnt, o_wrap_cnt, o_state, o_expected
   );

   modport slave (
      input  i_valid, i_cnt, i_clear,
      output o_locked, o_err_pulse, o_err_cnt, o_wrap_cnt, o_state, o_expected
   );
endinterface
`default_nettype wire

// File: rtl/count_seq_checker_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Event counter with synchronous clear. With SATURATE set it
//                sticks at all-ones, otherwise it rolls over.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b1
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             inc,
   input  wire logic             clr,
   output logic      [WIDTH-1:0] count
);

   logic at_limit;

   assign at_limit = SATURATE && (&count);

   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_limit) begin
         count <= count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/count_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_checker
//  Description : Receive-side monitor for a modulo (CNT_MAX+1) count stream.
//                Hunts for an in-range value, confirms LOCK_CNT consecutive
//                correct samples, then flags and counts sequence breaks and
//                counts correct wraps while locked.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_seq_checker
   import count_seq_checker_pkg::*;
#(
   parameter int CNT_W    = 7,
   parameter int CNT_MAX  = DEF_CNT_MAX,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8,
   parameter int WRAP_W   = 16
) (
   input wire logic           clk,
   input wire logic           reset,
   count_seq_checker_if.slave bus
);

   state_t           state;
   logic [3:0]       run;
   logic [CNT_W-1:0] expected;
   logic             err_pulse;

   logic             in_range;
   logic             match;
   logic [CNT_W-1:0] nxt;
   logic [3:0]       run_inc;
   logic             err_inc;
   logic             wrap_inc;

   // Sample qualification and successor of the current sample.
   assign in_range = (bus.i_cnt <= CNT_W'(CNT_MAX));
   assign match    = (bus.i_cnt == expected);
   assign nxt      = CNT_W'(next_count(32'(bus.i_cnt), CNT_MAX));
   assign run_inc  = run + 4'd1;

   // Statistics events only exist in LOCKED; a wrap is a correct arrival of 0.
   assign err_inc  = bus.i_valid && (state == LOCKED) && !match;
   assign wrap_inc = bus.i_valid && (state == LOCKED) && match && (bus.i_cnt == '0);

   // Hunt / sync / locked tracking with a registered one-cycle error pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= HUNT;
         run       <= 4'd0;
         expected  <= '0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         if (bus.i_valid) begin
            case (state)
               HUNT: begin
                  if (in_range) begin
                     expected <= nxt;
                     run      <= 4'd1;
                     state    <= SYNC;
                  end
               end
               SYNC: begin
                  if (match) begin
                     expected <= nxt;
                     run      <= run_inc;
                     if (run_inc == 4'(LOCK_CNT)) begin
                        state <= LOCKED;
                     end
                  end else if (in_range) begin
                     expected <= nxt;
                     run      <= 4'd1;
                  end else begin
                     run   <= 4'd0;
                     state <= HUNT;
                  end
               end
               LOCKED: begin
                  if (match) begin
                     expected <= nxt;
                  end else begin
                     err_pulse <= 1'b1;
                     if (in_range) begin
                        expected <= nxt;
                        run      <= 4'd1;
                        state    <= SYNC;
                     end else begin
                        run   <= 4'd0;
                        state <= HUNT;
                     end
                  end
               end
               default: begin
                  run   <= 4'd0;
                  state <= HUNT;
               end
            endcase
         end
      end
   end

   sat_counter #(
      .WIDTH    (ERR_W),
      .SATURATE (1'b1)
   ) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_inc),
      .clr   (bus.i_clear),
      .count (bus.o_err_cnt)
   );

   sat_counter #(
      .WIDTH    (WRAP_W),
      .SATURATE (1'b0)
   ) u_wrap_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (wrap_inc),
      .clr   (bus.i_clear),
      .count (bus.o_wrap_cnt)
   );

   assign bus.o_state     = state;
   assign bus.o_locked    = (state == LOCKED);
   assign bus.o_err_pulse = err_pulse;
   assign bus.o_expected  = expected;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_seq_checker
//  Description : Self-checking bench for count_seq_checker (default build and
//                a 2-bit error counter build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_seq_checker;

   typedef struct {
      logic        v;
      logic [6:0]  cnt;
      logic        clr;
      logic [1:0]  st;
      logic [6:0]  ex;
      logic        pu;
      logic [7:0]  er;
      logic [15:0] wr;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   count_seq_checker_if #(.CNT_W(7), .ERR_W(8), .WRAP_W(16)) bus1 ();
   count_seq_checker_if #(.CNT_W(7), .ERR_W(2), .WRAP_W(16)) bus2 ();

   count_seq_checker #(
      .CNT_W(7), .CNT_MAX(99), .LOCK_CNT(4), .ERR_W(8), .WRAP_W(16)
   ) dut1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   count_seq_checker #(
      .CNT_W(7), .CNT_MAX(99), .LOCK_CNT(4), .ERR_W(2), .WRAP_W(16)
   ) dut2 (
      .clk(clk), .reset(reset), .bus(bus2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic v, input int cnt, input logic clr,
                               input int st, input int ex, input logic pu,
                               input int er, input int wr);
      vec_t r;
      r.v = v; r.cnt = 7'(cnt); r.clr = clr; r.st = 2'(st); r.ex = 7'(ex);
      r.pu = pu; r.er = 8'(er); r.wr = 16'(wr);
      vecs.push_back(r);
   endfunction

   // Compare the selected DUT's outputs against one expected record.
   task automatic compare(input int sel, input string tag, input vec_t e);
      if (sel == 1) begin
         check({tag, " state"},  32'(bus1.o_state),     32'(e.st));
         check({tag, " expect"}, 32'(bus1.o_expected),  32'(e.ex));
         check({tag, " pulse"},  32'(bus1.o_err_pulse), 32'(e.pu));
         check({tag, " errcnt"}, 32'(bus1.o_err_cnt),   32'(e.er));
         check({tag, " wrap"},   32'(bus1.o_wrap_cnt),  32'(e.wr));
         check({tag, " locked"}, 32'(bus1.o_locked),    32'(e.st == 2'd2));
      end else begin
         check({tag, " state"},  32'(bus2.o_state),     32'(e.st));
         check({tag, " expect"}, 32'(bus2.o_expected),  32'(e.ex));
         check({tag, " pulse"},  32'(bus2.o_err_pulse), 32'(e.pu));
         check({tag, " errcnt"}, 32'(bus2.o_err_cnt),   32'(e.er));
         check({tag, " wrap"},   32'(bus2.o_wrap_cnt),  32'(e.wr));
         check({tag, " locked"}, 32'(bus2.o_locked),    32'(e.st == 2'd2));
      end
   endtask

   // Drive one sample, queue its expectation, pop and compare after the edge.
   task automatic apply(input int sel, input string tag, input vec_t v);
      vec_t e;
      @(negedge clk);
      if (sel == 1) begin
         bus1.i_valid = v.v; bus1.i_cnt = v.cnt; bus1.i_clear = v.clr;
      end else begin
         bus2.i_valid = v.v; bus2.i_cnt = v.cnt; bus2.i_clear = v.clr;
      end
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, " scoreboard"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         compare(sel, tag, e);
      end
      if (sel == 1) begin
         bus1.i_valid = 1'b0; bus1.i_clear = 1'b0;
      end else begin
         bus2.i_valid = 1'b0; bus2.i_clear = 1'b0;
      end
   endtask

   task automatic step(input int sel, input string tag, input logic v, input int cnt,
                       input logic clr, input int st, input int ex, input logic pu,
                       input int er, input int wr);
      vec_t r;
      r.v = v; r.cnt = 7'(cnt); r.clr = clr; r.st = 2'(st); r.ex = 7'(ex);
      r.pu = pu; r.er = 8'(er); r.wr = 16'(wr);
      apply(sel, tag, r);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t zero;
      zero.v = 0; zero.cnt = 0; zero.clr = 0; zero.st = 0; zero.ex = 0;
      zero.pu = 0; zero.er = 0; zero.wr = 0;

      bus1.i_valid = 1'b0; bus1.i_cnt = '0; bus1.i_clear = 1'b0;
      bus2.i_valid = 1'b0; bus2.i_cnt = '0; bus2.i_clear = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      compare(1, "reset1", zero);
      compare(2, "reset2", zero);
      reset = 1'b0;

      // ---------------- main vector table on the default build ----------------
      add(1, 120, 0, 0,  0, 0, 0, 0);       // out of range in HUNT
      add(1, 127, 0, 0,  0, 0, 0, 0);
      add(0,   5, 0, 0,  0, 0, 0, 0);       // idle
      for (int k = 0; k <= 3; k++) add(1, k, 0, (k == 3) ? 2 : 1, k + 1, 0, 0, 0);
      for (int k = 4; k <= 96; k++) add(1, k, 0, 2, k + 1, 0, 0, 0);
      add(1,  97, 0, 2, 98, 0, 0, 0);
      add(1,  98, 0, 2, 99, 0, 0, 0);
      add(1,  99, 0, 2,  0, 0, 0, 0);
      add(1,   0, 0, 2,  1, 0, 0, 1);       // correct wrap
      add(1,   1, 0, 2,  2, 0, 0, 1);
      for (int k = 2; k <= 10; k++) add(1, k, 0, 2, k + 1, 0, 0, 1);
      add(1,  12, 0, 1, 13, 1, 1, 1);       // break, in range
      add(1,  13, 0, 1, 14, 0, 1, 1);
      add(1,  14, 0, 1, 15, 0, 1, 1);
      add(1,  15, 0, 2, 16, 0, 1, 1);       // relock
      add(1, 110, 0, 0, 16, 1, 2, 1);       // break, out of range
      add(1, 120, 0, 0, 16, 0, 2, 1);
      add(0,  50, 0, 0, 16, 0, 2, 1);
      add(1,  50, 0, 1, 51, 0, 2, 1);
      add(1, 100, 0, 0, 51, 0, 2, 1);       // SYNC, out of range
      add(1,   5, 0, 1,  6, 0, 2, 1);
      add(1,   7, 0, 1,  8, 0, 2, 1);       // SYNC resync
      add(1,   8, 0, 1,  9, 0, 2, 1);
      add(1,   9, 0, 1, 10, 0, 2, 1);
      add(1,  10, 0, 2, 11, 0, 2, 1);
      add(0,   0, 1, 2, 11, 0, 0, 0);       // clear while idle
      add(1,  11, 0, 2, 12, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(1, $sformatf("vec%0d", i), vecs[i]);
      end

      // ---------------- saturation and clear priority, ERR_W=2 ----------------
      for (int k = 0; k <= 3; k++) step(2, $sformatf("sat_lock%0d", k), 1, k, 0, (k == 3) ? 2 : 1, k + 1, 0, 0, 0);
      for (int b = 0; b < 5; b++) begin
         int base;
         base = 10 + 20 * b;
         step(2, $sformatf("sat_brk%0d", b), 1, base, 0, 1, base + 1, 1, (b + 1 > 3) ? 3 : b + 1, 0);
         for (int j = 1; j <= 3; j++) begin
            step(2, $sformatf("sat_re%0d_%0d", b, j), 1, base + j, 0, (j == 3) ? 2 : 1,
                 base + j + 1, 0, (b + 1 > 3) ? 3 : b + 1, 0);
         end
      end
      step(2, "sat_clr", 1, 5, 1, 1, 6, 1, 0, 0);

      // ---------------- idle hold and asynchronous reset ----------------
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i <= 201; i++) begin
         step(1, $sformatf("w%0d", i), 1, i % 100, 0, (i < 3) ? 1 : 2, (i + 1) % 100, 0, 0,
              (i >= 200) ? 2 : ((i >= 100) ? 1 : 0));
      end
      for (int i = 0; i < 3; i++) step(1, $sformatf("idle%0d", i), 0, 77, 0, 2, 2, 0, 0, 2);

      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      compare(1, "async_rst", zero);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) step(1, $sformatf("relock%0d", k), 1, 40 + k, 0, (k == 3) ? 2 : 1, 41 + k, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
